// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the 4-bit CPU control path and its ALU.
//   - ALU opcodes (AluAdd..AluPassB), shared with the ALU beside cpu_control
//   - control opcodes (OpNop..OpHalt) for the upper instruction nibble
//   - sequencer state encoding and decoded-instruction bundle
//   - 8-bit instruction field positions: {op[7:4], imm[3:0]}
package cpu_pkg;

    // ALU opcodes; also the low three bits of instruction opcodes 0000-0110
    localparam logic [2:0] AluAdd   = 3'd0;
    localparam logic [2:0] AluSub   = 3'd1;
    localparam logic [2:0] AluAnd   = 3'd2;
    localparam logic [2:0] AluOr    = 3'd3;
    localparam logic [2:0] AluXor   = 3'd4;
    localparam logic [2:0] AluPassA = 3'd5;
    localparam logic [2:0] AluPassB = 3'd6;

    // Control opcodes (upper instruction nibble)
    localparam logic [3:0] OpNop  = 4'h7;
    localparam logic [3:0] OpLdi0 = 4'h8;
    localparam logic [3:0] OpLdi1 = 4'h9;
    localparam logic [3:0] OpMov  = 4'hA;
    localparam logic [3:0] OpJmp  = 4'hB;
    localparam logic [3:0] OpJz   = 4'hC;
    localparam logic [3:0] OpJc   = 4'hD;
    localparam logic [3:0] OpOut  = 4'hE;
    localparam logic [3:0] OpHalt = 4'hF;

    // Instruction word layout
    localparam int unsigned InstrW = 8;
    localparam int unsigned OpMsb  = 7;
    localparam int unsigned OpLsb  = 4;
    localparam int unsigned ImmMsb = 3;
    localparam int unsigned ImmLsb = 0;

    // Instruction register value after reset: a NOP
    localparam logic [InstrW-1:0] InstrReset = 8'h70;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StOut,
        StHalt
    } state_e;

    typedef enum logic [1:0] {
        JmpNone,
        JmpAlways,
        JmpZero,
        JmpCarry
    } jump_e;

    typedef struct packed {
        logic  is_alu;
        logic  wr_r0;
        logic  wr_r1;
        logic  sel_imm;    // register write data comes from imm
        jump_e jump_kind;
        logic  is_out;
        logic  is_halt;
    } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: purely combinational instruction decoder.
// Ports:
//   instr  in   8      instruction word {op, imm}
//   dec    out  dec_t  {is_alu, wr_r0, wr_r1, sel_imm, jump_kind, is_out, is_halt}
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [InstrW-1:0] instr,
    output dec_t              dec
);

    logic [3:0] op;
    assign op = instr[OpMsb:OpLsb];

    always_comb begin
        dec           = '0;
        dec.jump_kind = JmpNone;
        case (op)
            OpNop:  ;
            OpLdi0: begin
                dec.wr_r0   = 1'b1;
                dec.sel_imm = 1'b1;
            end
            OpLdi1: begin
                dec.wr_r1   = 1'b1;
                dec.sel_imm = 1'b1;
            end
            OpMov:  dec.wr_r1     = 1'b1;
            OpJmp:  dec.jump_kind = JmpAlways;
            OpJz:   dec.jump_kind = JmpZero;
            OpJc:   dec.jump_kind = JmpCarry;
            OpOut:  dec.is_out    = 1'b1;
            OpHalt: dec.is_halt   = 1'b1;
            // 0000-0110: ALU operations write R0 and the flags
            default: begin
                dec.is_alu = 1'b1;
                dec.wr_r0  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// cpu_control: fetch/decode/execute sequencer for the 4-bit CPU.
// Holds PC, R0, R1 and the carry/zero flags; drives the external ALU.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_addr/req         instruction fetch address (= pc) and request
//   imem_data/ack         instruction word, valid with ack
//   alu_a/alu_b/alu_op    ALU operands (R0, R1) and opcode
//   alu_result/carry/zero ALU outputs, combinational from the operands
//   out_data/valid/ready  output port, R0 snapshot taken when OUT executes
//   halted                CPU stopped on HALT
module cpu_control
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [InstrW-1:0] imem_data,
    input  logic              imem_ack,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   r0_q, r1_q, out_data_q;
    logic                c_q, z_q;
    logic [InstrW-1:0]   instr_q;

    dec_t                dec;
    logic                jump_taken;
    logic [PC_W-1:0]     pc_inc, imm_pc;
    logic [DATA_W-1:0]   imm_data;

    cpu_decode u_decode (
        .instr (instr_q),
        .dec   (dec)
    );

    assign pc_inc   = pc_q + PC_W'(1);
    assign imm_pc   = PC_W'(instr_q[ImmMsb:ImmLsb]);
    assign imm_data = DATA_W'(instr_q[ImmMsb:ImmLsb]);

    always_comb begin
        unique case (dec.jump_kind)
            JmpAlways: jump_taken = 1'b1;
            JmpZero:   jump_taken = z_q;
            JmpCarry:  jump_taken = c_q;
            default:   jump_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (imem_ack) state_d = StExec;
            StExec: begin
                if (dec.is_out) begin
                    state_d = StOut;
                end else if (dec.is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StFetch;
                end
            end
            StOut:   if (out_ready) state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        imem_req  = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;
        alu_op    = AluPassA;
        unique case (state_q)
            StFetch: imem_req  = 1'b1;
            StExec:  if (dec.is_alu) alu_op = instr_q[OpLsb +: 3];
            StOut:   out_valid = 1'b1;
            StHalt:  halted    = 1'b1;
            default: ;
        endcase
    end

    // Datapath: instruction capture, register/flag/pc updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            instr_q    <= InstrReset;
            out_data_q <= '0;
        end else begin
            if (state_q == StFetch && imem_ack) begin
                instr_q <= imem_data;
            end
            if (state_q == StExec) begin
                if (dec.wr_r0) r0_q <= dec.sel_imm ? imm_data : alu_result;
                if (dec.wr_r1) r1_q <= dec.sel_imm ? imm_data : r0_q;
                if (dec.is_alu) begin
                    c_q <= alu_carry;
                    z_q <= alu_zero;
                end
                // OUT holds pc until the transfer completes
                if (dec.is_out) begin
                    out_data_q <= r0_q;
                end else if (jump_taken) begin
                    pc_q <= imm_pc;
                end else begin
                    pc_q <= pc_inc;
                end
            end
            if (state_q == StOut && out_ready) begin
                pc_q <= pc_inc;
            end
        end
    end

    assign imem_addr = pc_q;
    assign alu_a     = r0_q;
    assign alu_b     = r1_q;
    assign out_data  = out_data_q;

endmodule
